// File: rtl/lynx_mem_ctrl.sv
// Lynx 48K/96K/128K memory and IO controller: bank registers, read-source decode,
// write strobes and CPU/video wait arbitration.
module lynx_mem_ctrl #(
  parameter int MODEL     = 0,
  parameter int RAM_PAGES = 1,
  parameter int WAIT_MAX  = 3,
  localparam int RPW = (RAM_PAGES > 1) ? $clog2(RAM_PAGES) : 1,
  localparam int CW  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           ce_i,
  input  logic           mreq_n_i,
  input  logic           iorq_n_i,
  input  logic           rd_n_i,
  input  logic           wr_n_i,
  input  logic [15:0]    a_i,
  input  logic [7:0]     d_i,
  input  logic           vid_active_i,
  input  logic           vid_slot_i,
  output logic [14:0]    rom_a_o,
  output logic [RPW-1:0] ram_page_o,
  output logic           ram_we_n_o,
  output logic           vrb_we_n_o,
  output logic           vgg_we_n_o,
  output logic [2:0]     rd_sel_o,
  output logic           wait_n_o,
  output logic           altg_o,
  output logic           motor_o,
  output logic [7:0]     reg7f_o
);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  logic [7:0]     reg7f_q, reg7f_d;
  logic [5:2]     reg80_q, reg80_d;   // bit 6 has no consumer, so it is not stored
  logic           motor_q, motor_d;
  logic [RPW-1:0] ext_q, ext_d;
  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           slot_q;
  logic           wait_n_q;
  logic           io_wr;
  logic           vacc;
  logic           mem_wr;

  assign io_wr  = ce_i & ~iorq_n_i & ~wr_n_i;
  assign mem_wr = ~mreq_n_i & ~wr_n_i;

  always_comb begin
    reg7f_d = reg7f_q;
    reg80_d = reg80_q;
    motor_d = motor_q;
    ext_d   = ext_q;
    if (io_wr) begin
      if (a_i[6:0] == 7'h7F) reg7f_d = d_i;
      if (a_i[7] & ~a_i[6] & ~a_i[2] & ~a_i[1]) begin
        reg80_d = d_i[5:2];
        motor_d = d_i[1];
      end
      if (MODEL >= 1 && a_i[7:0] == 8'hFF) ext_d = d_i[RPW-1:0];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      reg7f_q <= 8'h00;
      reg80_q <= 4'b0011;
      motor_q <= 1'b0;
      ext_q   <= '0;
    end else begin
      reg7f_q <= reg7f_d;
      reg80_q <= reg80_d;
      motor_q <= motor_d;
      ext_q   <= ext_d;
    end
  end

  // Read source: earlier rules shadow later ones.
  always_comb begin
    rd_sel_o = 3'd0;
    if (!rd_n_i) begin
      if (!reg7f_q[4] && a_i[15:14] == 2'b00)       rd_sel_o = 3'd1;
      else if (!reg7f_q[4] && a_i[15:13] == 3'b010) rd_sel_o = (MODEL >= 1) ? 3'd1 : 3'd2;
      else if (!reg7f_q[5])                         rd_sel_o = 3'd3;
      else if (reg7f_q[6] && !reg80_q[2])           rd_sel_o = 3'd4;
      else if (reg7f_q[6] && !reg80_q[3])           rd_sel_o = 3'd5;
      else if (!iorq_n_i && a_i[7:0] == 8'h80)      rd_sel_o = 3'd6;
      else                                          rd_sel_o = 3'd0;
    end
  end

  assign vacc = ~mreq_n_i & ((rd_sel_o == 3'd4) | (rd_sel_o == 3'd5) |
                (~wr_n_i & reg80_q[5] & (reg7f_q[1] | reg7f_q[2])));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= 1'b0;
      wait_n_q <= 1'b1;
    end else begin
      // A slot pulse between ce edges is held until the next ce.
      if (state_q != WAIT)  slot_q <= 1'b0;
      else if (vid_slot_i)  slot_q <= 1'b1;
      if (ce_i) begin
        case (state_q)
          IDLE: begin
            if (vacc) begin
              if (vid_active_i) begin
                state_q  <= WAIT;
                cnt_q    <= '0;
                wait_n_q <= 1'b0;
              end else begin
                state_q  <= GRANT;
              end
            end
          end
          WAIT: begin
            if (mreq_n_i) begin
              state_q  <= IDLE;
              wait_n_q <= 1'b1;
            end else if (slot_q | vid_slot_i | ~vid_active_i |
                         (cnt_q == CW'(WAIT_MAX - 1))) begin
              state_q  <= GRANT;
              wait_n_q <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + CW'(1);
            end
          end
          GRANT: begin
            if (mreq_n_i) state_q <= IDLE;
          end
          default: begin
            state_q  <= IDLE;
            wait_n_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ram_we_n_o = ~(mem_wr & ~reg7f_q[0]);
  assign vrb_we_n_o = ~(mem_wr & reg7f_q[1] & reg80_q[5] & (state_q == GRANT));
  assign vgg_we_n_o = ~(mem_wr & reg7f_q[2] & reg80_q[5] & (state_q == GRANT));

  assign rom_a_o    = (MODEL >= 1) ? a_i[14:0] : {1'b0, a_i[13:0]};
  assign ram_page_o = (MODEL >= 1) ? ext_q : '0;
  assign wait_n_o   = wait_n_q;
  assign altg_o     = reg80_q[4];
  assign motor_o    = motor_q;
  assign reg7f_o    = reg7f_q;

endmodule

// File: tb/tb_lynx_mem_ctrl.sv
// Scoreboarded random/directed bench for lynx_mem_ctrl, MODEL 0 and MODEL 1 side by side.
module tb_lynx_mem_ctrl;

  localparam int WMAX = 3;

  typedef struct packed {
    logic [14:0] rom_a;
    logic [1:0]  ram_page;
    logic        ram_we_n;
    logic        vrb_we_n;
    logic        vgg_we_n;
    logic [2:0]  rd_sel;
    logic        wait_n;
    logic        altg;
    logic        motor;
    logic [7:0]  reg7f;
  } obs_t;

  typedef struct packed {
    obs_t e0;
    obs_t e1;
  } pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, ce = 1'b0, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        vid_active = 1'b0, vid_slot = 1'b0;
  logic [15:0] a = 16'h0;
  logic [7:0]  d = 8'h0;
  bit          rand_ce = 1'b0;

  logic [14:0] rom_a0, rom_a1;
  logic [0:0]  rp0;
  logic [1:0]  rp1;
  logic        rwe0, vrb0, vgg0, wn0, altg0, mot0;
  logic        rwe1, vrb1, vgg1, wn1, altg1, mot1;
  logic [2:0]  rs0, rs1;
  logic [7:0]  r7f0, r7f1;

  lynx_mem_ctrl #(.MODEL(0), .RAM_PAGES(1), .WAIT_MAX(WMAX)) u_m0 (
    .clock_i(clk), .reset_i(reset), .ce_i(ce), .mreq_n_i(mreq_n), .iorq_n_i(iorq_n),
    .rd_n_i(rd_n), .wr_n_i(wr_n), .a_i(a), .d_i(d), .vid_active_i(vid_active),
    .vid_slot_i(vid_slot), .rom_a_o(rom_a0), .ram_page_o(rp0), .ram_we_n_o(rwe0),
    .vrb_we_n_o(vrb0), .vgg_we_n_o(vgg0), .rd_sel_o(rs0), .wait_n_o(wn0),
    .altg_o(altg0), .motor_o(mot0), .reg7f_o(r7f0));

  lynx_mem_ctrl #(.MODEL(1), .RAM_PAGES(4), .WAIT_MAX(WMAX)) u_m1 (
    .clock_i(clk), .reset_i(reset), .ce_i(ce), .mreq_n_i(mreq_n), .iorq_n_i(iorq_n),
    .rd_n_i(rd_n), .wr_n_i(wr_n), .a_i(a), .d_i(d), .vid_active_i(vid_active),
    .vid_slot_i(vid_slot), .rom_a_o(rom_a1), .ram_page_o(rp1), .ram_we_n_o(rwe1),
    .vrb_we_n_o(vrb1), .vgg_we_n_o(vgg1), .rd_sel_o(rs1), .wait_n_o(wn1),
    .altg_o(altg1), .motor_o(mot1), .reg7f_o(r7f1));

  // Reference model state, one copy per instance (index = MODEL).
  logic [7:0] m7f[2];
  logic [5:2] m80[2];
  logic       mmot[2];
  logic [7:0] mext[2];
  int         phase[2];   // 0 = no video access, 1 = CPU held off, 2 = CPU granted
  int         waited[2];
  bit         slot[2];

  pair_t q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic model_reset(input int m);
    m7f[m] = 8'h00; m80[m] = 4'b0011; mmot[m] = 1'b0; mext[m] = 8'h00;
    phase[m] = 0; waited[m] = 0; slot[m] = 1'b0;
  endtask

  function automatic logic [2:0] exp_rdsel(input int m);
    if (rd_n) return 3'd0;
    if (!m7f[m][4] && a[15:14] == 2'b00) return 3'd1;
    if (!m7f[m][4] && a[15:13] == 3'b010) return (m >= 1) ? 3'd1 : 3'd2;
    if (!m7f[m][5]) return 3'd3;
    if (m7f[m][6] && !m80[m][2]) return 3'd4;
    if (m7f[m][6] && !m80[m][3]) return 3'd5;
    if (!iorq_n && a[7:0] == 8'h80) return 3'd6;
    return 3'd0;
  endfunction

  function automatic obs_t exp_obs(input int m);
    obs_t o;
    logic wr_cyc;
    wr_cyc     = !mreq_n && !wr_n;
    o.rom_a    = (m >= 1) ? a[14:0] : {1'b0, a[13:0]};
    o.ram_page = (m >= 1) ? mext[m][1:0] : 2'b00;
    o.ram_we_n = !(wr_cyc && !m7f[m][0]);
    o.vrb_we_n = !(wr_cyc && m7f[m][1] && m80[m][5] && phase[m] == 2);
    o.vgg_we_n = !(wr_cyc && m7f[m][2] && m80[m][5] && phase[m] == 2);
    o.rd_sel   = exp_rdsel(m);
    o.wait_n   = (phase[m] != 1);
    o.altg     = m80[m][4];
    o.motor    = mmot[m];
    o.reg7f    = m7f[m];
    return o;
  endfunction

  // Effect of one rising clock edge, using the inputs held across that edge.
  task automatic model_edge(input int m);
    logic [2:0] rs;
    logic vacc;
    if (reset) return;
    rs   = exp_rdsel(m);
    vacc = !mreq_n && (rs == 3'd4 || rs == 3'd5 ||
           (!wr_n && m80[m][5] && (m7f[m][1] || m7f[m][2])));
    if (!ce) begin
      if (phase[m] == 1 && vid_slot) slot[m] = 1'b1;
      return;
    end
    if (phase[m] == 0) begin
      if (vacc) begin
        if (vid_active) begin phase[m] = 1; waited[m] = 0; slot[m] = 1'b0; end
        else phase[m] = 2;
      end
    end else if (phase[m] == 1) begin
      if (mreq_n) phase[m] = 0;
      else if (slot[m] || vid_slot || !vid_active || waited[m] >= WMAX - 1) phase[m] = 2;
      else waited[m]++;
      if (phase[m] != 1) slot[m] = 1'b0;
    end else begin
      if (mreq_n) phase[m] = 0;
    end
    if (!iorq_n && !wr_n) begin
      if (a[6:0] == 7'h7F) m7f[m] = d;
      if (a[7] && !a[6] && !a[2] && !a[1]) begin m80[m] = d[5:2]; mmot[m] = d[1]; end
      if (m >= 1 && a[7:0] == 8'hFF) mext[m] = d;
    end
  endtask

  task automatic tick(input logic nmreq, input logic niorq, input logic nrd, input logic nwr,
                      input logic [15:0] na, input logic [7:0] nd,
                      input logic nva, input logic nvs, input logic nrst);
    pair_t p;
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    ce = rand_ce ? 1'($urandom_range(0, 1)) : ~ce;
    mreq_n = nmreq; iorq_n = niorq; rd_n = nrd; wr_n = nwr;
    a = na; d = nd; vid_active = nva; vid_slot = nvs; reset = nrst;
    if (reset) begin model_reset(0); model_reset(1); end
    p.e0 = exp_obs(0);
    p.e1 = exp_obs(1);
    q.push_back(p);
  endtask

  task automatic cyc(input logic nmreq, input logic niorq, input logic nrd, input logic nwr,
                     input logic [15:0] na, input logic [7:0] nd, input logic nva, input int n);
    repeat (n) tick(nmreq, niorq, nrd, nwr, na, nd, nva, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    cyc(1, 1, 1, 1, 16'h0000, 8'h00, 1'b0, n);
  endtask

  task automatic out_port(input logic [7:0] port, input logic [7:0] val);
    cyc(1, 0, 1, 0, {8'h00, port}, val, 1'b0, 2);
    idle(1);
  endtask

  task automatic check(input int m, input obs_t got, input obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL outputs dut_model%0d t=%0t got rd_sel=%0d wait_n=%b we(ram,vrb,vgg)=%b%b%b rom_a=%h page=%h reg7f=%h altg=%b motor=%b, want rd_sel=%0d wait_n=%b we=%b%b%b rom_a=%h page=%h reg7f=%h altg=%b motor=%b",
                  m, $time, got.rd_sel, got.wait_n, got.ram_we_n, got.vrb_we_n, got.vgg_we_n,
                  got.rom_a, got.ram_page, got.reg7f, got.altg, got.motor,
                  exp.rd_sel, exp.wait_n, exp.ram_we_n, exp.vrb_we_n, exp.vgg_we_n,
                  exp.rom_a, exp.ram_page, exp.reg7f, exp.altg, exp.motor);
  endtask

  initial begin : monitor
    pair_t e;
    obs_t  g0, g1;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        g0 = '{rom_a0, {1'b0, rp0}, rwe0, vrb0, vgg0, rs0, wn0, altg0, mot0, r7f0};
        g1 = '{rom_a1, rp1, rwe1, vrb1, vgg1, rs1, wn1, altg1, mot1, r7f1};
        check(0, g0, e.e0);
        check(1, g1, e.e1);
      end
    end
  end

  initial begin : stim
    logic        va;
    logic [15:0] ra;
    logic [7:0]  port;
    int          len, op;
    model_reset(0);
    model_reset(1);
    repeat (3) tick(1, 1, 1, 1, 16'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // ROM and 0xFF-constant regions, extended page
    out_port(8'h7F, 8'h00);
    cyc(0, 1, 0, 1, 16'h0000, 8'h00, 1'b0, 2);
    cyc(0, 1, 0, 1, 16'h4000, 8'h00, 1'b0, 2);
    out_port(8'hFF, 8'h01);
    cyc(0, 1, 0, 1, 16'h4000, 8'h00, 1'b0, 2);
    idle(1);
    // Video writes: free, slot-granted, forced, vid_active drop, aborted
    out_port(8'h80, 8'h24);
    out_port(8'h7F, 8'h02);
    cyc(0, 1, 1, 0, 16'h8000, 8'h5A, 1'b0, 6);
    idle(2);
    cyc(0, 1, 1, 0, 16'h8000, 8'h5A, 1'b1, 4);
    tick(0, 1, 1, 0, 16'h8000, 8'h5A, 1'b1, 1'b1, 1'b0);
    cyc(0, 1, 1, 0, 16'h8000, 8'h5A, 1'b1, 4);
    idle(2);
    cyc(0, 1, 1, 0, 16'h8000, 8'h5A, 1'b1, 10);
    idle(2);
    cyc(0, 1, 1, 0, 16'h9000, 8'h11, 1'b1, 2);
    cyc(0, 1, 1, 0, 16'h9000, 8'h11, 1'b0, 4);
    idle(2);
    cyc(0, 1, 1, 0, 16'h9000, 8'h11, 1'b1, 3);
    idle(3);
    // Video-bank reads and IN 0x80
    out_port(8'h7F, 8'h60);
    out_port(8'h80, 8'h08);
    cyc(0, 1, 0, 1, 16'hC000, 8'h00, 1'b0, 2);
    out_port(8'h80, 8'h04);
    cyc(0, 1, 0, 1, 16'hC000, 8'h00, 1'b0, 2);
    out_port(8'h7F, 8'h30);
    cyc(1, 0, 0, 1, 16'h0080, 8'h00, 1'b0, 2);
    out_port(8'h80, 8'h12);
    // Reset while the CPU is held off
    out_port(8'h80, 8'h24);
    out_port(8'h7F, 8'h06);
    cyc(0, 1, 1, 0, 16'hA000, 8'h33, 1'b1, 3);
    tick(0, 1, 1, 0, 16'hA000, 8'h33, 1'b1, 1'b0, 1'b1);
    cyc(0, 1, 1, 0, 16'hA000, 8'h33, 1'b1, 2);
    idle(3);

    rand_ce = 1'b1;
    for (int t = 0; t < 300; t++) begin
      op  = $urandom_range(0, 7);
      len = $urandom_range(2, 8);
      va  = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      case ($urandom_range(0, 4))
        0: port = 8'h7F;
        1: port = 8'h80;
        2: port = 8'hFF;
        3: port = 8'h84;
        default: port = 8'($urandom);
      endcase
      for (int k = 0; k < len; k++) begin
        logic nm, ni, nr, nw;
        {nm, ni, nr, nw} = 4'b1111;
        case (op)
          0: begin ni = 0; nw = 0; ra = {8'h00, port}; end
          1: begin ni = 0; nr = 0; ra = (port == 8'h84) ? 16'h0080 : ra; end
          2, 3: begin nm = 0; nr = 0; end
          4, 5, 7: begin nm = 0; nw = 0; end
          default: ;
        endcase
        if ($urandom_range(0, 5) == 0) va = ~va;
        tick(nm, ni, nr, nw, ra, 8'($urandom), va,
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 80) == 0));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain queue left=%0d want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
